// File: rtl/pl4_wb.sv
// pl4_wb: writeback stage with 32x32 register file, forwarding register, a0 mirror and retire counter; `WB_BYPASS_EN adds write-through reads.
module pl4_wb #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_wb_val,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic            i_wb_en,
    input  logic            i_valid,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_val,
    output logic [XLEN-1:0] o_rs2_val,
    output logic            o_ff_valid,
    output logic [AW-1:0]   o_ff_addr,
    output logic [XLEN-1:0] o_ff_val,
    output logic [XLEN-1:0] o_a0,
    output logic [31:0]     o_retired
);
    logic [XLEN-1:0] regs [NREGS];
    logic commit;
    assign commit = i_valid & i_wb_en & (i_wb_addr != '0);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            o_ff_valid <= 1'b0;
            o_ff_addr  <= '0;
            o_ff_val   <= '0;
            o_a0       <= '0;
            o_retired  <= '0;
        end else begin
            if (commit) regs[i_wb_addr] <= i_wb_val;
            if (commit && i_wb_addr == AW'(10)) o_a0 <= i_wb_val;
            if (i_valid) o_retired <= o_retired + 32'd1;
            o_ff_valid <= commit;
            o_ff_addr  <= i_wb_addr;
            o_ff_val   <= i_wb_val;
        end
    end
`ifdef WB_BYPASS_EN
    assign o_rs1_val = (i_rs1_addr == '0) ? '0 : (commit && i_rs1_addr == i_wb_addr) ? i_wb_val : regs[i_rs1_addr];
    assign o_rs2_val = (i_rs2_addr == '0) ? '0 : (commit && i_rs2_addr == i_wb_addr) ? i_wb_val : regs[i_rs2_addr];
`else
    assign o_rs1_val = (i_rs1_addr == '0) ? '0 : regs[i_rs1_addr];
    assign o_rs2_val = (i_rs2_addr == '0) ? '0 : regs[i_rs2_addr];
`endif
endmodule

// File: tb/tb_pl4_wb.sv
// tb_pl4_wb: randomized and directed checks of pl4_wb against an array-based register file model.
module tb_pl4_wb;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_wb_val = '0;
    logic [4:0]  i_wb_addr = '0;
    logic        i_wb_en = 1'b0;
    logic        i_valid = 1'b0;
    logic [4:0]  i_rs1_addr = '0;
    logic [4:0]  i_rs2_addr = '0;
    logic [31:0] o_rs1_val, o_rs2_val, o_ff_val, o_a0, o_retired;
    logic        o_ff_valid;
    logic [4:0]  o_ff_addr;

    pl4_wb dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_val(i_wb_val), .i_wb_addr(i_wb_addr),
        .i_wb_en(i_wb_en), .i_valid(i_valid), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_ff_valid(o_ff_valid), .o_ff_addr(o_ff_addr),
        .o_ff_val(o_ff_val), .o_a0(o_a0), .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_ret = '0;
    logic        m_ffv = 1'b0;
    logic [4:0]  m_ffa = '0;
    logic [31:0] m_ffd = '0;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [31:0] exp_rd(input logic [4:0] r);
        logic c;
        c = i_valid && i_wb_en && i_wb_addr != 0;
        if (r == 0) return 32'd0;
        if (BYPASS && c && r == i_wb_addr) return i_wb_val;
        return m_regs[r];
    endfunction

    task automatic drive(input logic v, input logic e, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge i_clk);
        i_valid = v; i_wb_en = e; i_wb_addr = a; i_wb_val = d; i_rs1_addr = r1; i_rs2_addr = r2;
    endtask

    task automatic tick();
        logic c;
        @(posedge i_clk);
        c = i_valid && i_wb_en && i_wb_addr != 0;
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_ret = '0; m_ffv = 1'b0; m_ffa = '0; m_ffd = '0;
        end else begin
            if (c) m_regs[i_wb_addr] = i_wb_val;
            if (i_valid) m_ret = m_ret + 32'd1;
            m_ffv = c; m_ffa = i_wb_addr; m_ffd = i_wb_val;
        end
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 5'($urandom), $urandom, 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 1'b1, 5'd7, 32'hABCD, 5'd0, 5'd0);
        i_rst_n = 1'b0;
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        i_rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(r), 5'(31 - r));
            #1;
            total++;
            if (o_rs1_val !== 32'd0) begin
                $display("FAIL reset_rs1 x%0d got %h want 0", r, o_rs1_val);
            end else passed++;
            total++;
            if (o_rs2_val !== 32'd0) begin
                $display("FAIL reset_rs2 x%0d got %h want 0", 31 - r, o_rs2_val);
            end else passed++;
        end
        total++;
        if (o_retired !== 32'd0 || o_a0 !== 32'd0 || o_ff_valid !== 1'b0) begin
            $display("FAIL reset_outs got ret=%h a0=%h ffv=%b want 0 0 0", o_retired, o_a0, o_ff_valid);
        end else passed++;
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        #1;
        total++;
        if (o_rs1_val !== 32'hDEADBEEF || o_rs2_val !== 32'hDEADBEEF) begin
            $display("FAIL basic_rd got %h %h want deadbeef", o_rs1_val, o_rs2_val);
        end else passed++;
        total++;
        if (o_ff_valid !== 1'b1 || o_ff_addr !== 5'd5 || o_ff_val !== 32'hDEADBEEF) begin
            $display("FAIL basic_ff got %b %0d %h want 1 5 deadbeef", o_ff_valid, o_ff_addr, o_ff_val);
        end else passed++;
        tick();
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        #1;
        total++;
        if (o_rs1_val !== 32'd0) begin
            $display("FAIL x0_rd_same got %h want 0", o_rs1_val);
        end else passed++;
        tick();
        total++;
        if (o_rs1_val !== 32'd0 || o_ff_valid !== 1'b0) begin
            $display("FAIL x0_after got rd=%h ffv=%b want 0 0", o_rs1_val, o_ff_valid);
        end else passed++;
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        want = BYPASS ? 32'h55 : 32'd0;
        drive(1'b1, 1'b1, 5'd10, 32'h55, 5'd0, 5'd10);
        #1;
        total++;
        if (o_rs2_val !== want) begin
            $display("FAIL bypass_rd got %h want %h", o_rs2_val, want);
        end else passed++;
        tick();
        total++;
        if (o_a0 !== 32'h55 || o_rs2_val !== 32'h55) begin
            $display("FAIL bypass_a0 got a0=%h rd=%h want 55 55", o_a0, o_rs2_val);
        end else passed++;
    endtask

    task automatic test_counter();
        i_rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        i_rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        drive(1'b0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 5'($urandom), $urandom, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        total++;
        if (o_retired !== 32'd5) begin
            $display("FAIL counter_5 got %0d want 5", o_retired);
        end else passed++;
        for (int r = 0; r < 32; r += 2) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(r), 5'(r + 1));
            #1;
            total++;
            if (o_rs1_val !== 32'd0 || o_rs2_val !== 32'd0) begin
                $display("FAIL counter_regs x%0d/x%0d got %h %h want 0 0", r, r + 1, o_rs1_val, o_rs2_val);
            end else passed++;
        end
        @(negedge i_clk);
        force dut.o_retired = 32'hFFFF_FFFF;
        #1;
        release dut.o_retired;
        m_ret = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        total++;
        if (o_retired !== 32'd0) begin
            $display("FAIL counter_wrap got %h want 0", o_retired);
        end else passed++;
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b1, 5'd3, 32'd7, 5'd0, 5'd0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        #1;
        total++;
        if (o_rs1_val !== 32'd0 || o_ff_valid !== 1'b0) begin
            $display("FAIL collision got rd=%h ffv=%b want 0 0", o_rs1_val, o_ff_valid);
        end else passed++;
    endtask

    task automatic test_random();
        logic [4:0] a, r1, r2;
        for (int k = 0; k < 400; k++) begin
            a = 5'($urandom_range(0, 15));
            r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 15));
            r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, $urandom, r1, r2);
            i_rst_n = ($urandom_range(0, 49) != 0);
            #1;
            total++;
            if (o_rs1_val !== exp_rd(r1) || o_rs2_val !== exp_rd(r2)) begin
                $display("FAIL rand_rd cyc %0d x%0d/x%0d got %h %h want %h %h", k, r1, r2,
                         o_rs1_val, o_rs2_val, exp_rd(r1), exp_rd(r2));
            end else passed++;
            tick();
            total++;
            if (o_ff_valid !== m_ffv || o_ff_addr !== m_ffa || o_ff_val !== m_ffd) begin
                $display("FAIL rand_ff cyc %0d got %b %0d %h want %b %0d %h", k, o_ff_valid, o_ff_addr,
                         o_ff_val, m_ffv, m_ffa, m_ffd);
            end else passed++;
            total++;
            if (o_a0 !== m_regs[10] || o_retired !== m_ret) begin
                $display("FAIL rand_state cyc %0d got a0=%h ret=%0d want %h %0d", k, o_a0, o_retired,
                         m_regs[10], m_ret);
            end else passed++;
        end
        i_rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_counter();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
